// File: rtl/vga_digit_update_sched.sv
// Frame-synchronous scheduler for the shared digit display path.
// Define VGA_SCHED_RR_EN for round-robin arbitration; fixed port-0 priority otherwise.
module vga_digit_update_sched #(
   parameter int unsigned V_AV           = 480,
   parameter int unsigned MIN_FRAMES     = 30,
   parameter int unsigned TIMEOUT_FRAMES = 600,
   parameter int unsigned CNT_W          = 10
) (
   input  logic       pixClk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [1:0] req,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   output logic [1:0] ack,
   output logic       err,
   output logic [3:0] digit,
   output logic       digitEn,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLANK = 2'd1,
      COMMIT     = 2'd2,
      HOLD       = 2'd3
   } state_t;

   localparam logic [9:0]       V_AV_C = 10'(V_AV);
   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_FRAMES);
   localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT_FRAMES);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       ack_q, ack_d;
   logic [1:0]       mask_q, mask_d;
   logic             err_q, err_d;
   logic             pidx_q, pidx_d;
   logic [3:0]       pdig_q, pdig_d;
   logic [3:0]       digit_q, digit_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] idle_q, idle_d;
`ifdef VGA_SCHED_RR_EN
   logic             rr_q, rr_d;
`endif

   logic       frame_tick;
   logic [1:0] req_eff;
   logic       win_vld;
   logic       win_idx;
   logic [3:0] win_dig;
   logic       win_bad;

   assign frame_tick = (x == 10'd0) && (y == V_AV_C);

   // A port is ignored during its ack cycle and the one after it.
   always_comb begin
      req_eff = req & ~(ack_q | mask_q);
      win_vld = |req_eff;
`ifdef VGA_SCHED_RR_EN
      win_idx = req_eff[1] & (~req_eff[0] | rr_q);
`else
      win_idx = ~req_eff[0];
`endif
      win_dig = win_idx ? digit1 : digit0;
      win_bad = win_dig > 4'd9;
   end

   always_ff @(posedge pixClk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ack_q   <= 2'b00;
         mask_q  <= 2'b00;
         err_q   <= 1'b0;
         pidx_q  <= 1'b0;
         pdig_q  <= 4'd0;
         digit_q <= 4'd0;
         en_q    <= 1'b0;
         hold_q  <= '0;
         idle_q  <= '0;
`ifdef VGA_SCHED_RR_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         pidx_q  <= pidx_d;
         pdig_q  <= pdig_d;
         digit_q <= digit_d;
         en_q    <= en_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
`ifdef VGA_SCHED_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld && !win_bad) state_d = WAIT_BLANK;
         end
         WAIT_BLANK: begin
            if (frame_tick) state_d = COMMIT;
         end
         COMMIT: begin
            state_d = (MIN_C != '0) ? HOLD : IDLE;
         end
         HOLD: begin
            if (frame_tick && hold_q <= ONE_C) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack_d   = 2'b00;
      mask_d  = ack_q;
      err_d   = 1'b0;
      pidx_d  = pidx_q;
      pdig_d  = pdig_q;
      digit_d = digit_q;
      en_d    = en_q;
      hold_d  = hold_q;
      idle_d  = idle_q;
`ifdef VGA_SCHED_RR_EN
      rr_d    = rr_q;
`endif

      // Inactivity timeout; a commit in the same cycle overrides it below.
      if (TO_C != '0 && frame_tick && en_q && state_q != COMMIT) begin
         if (idle_q < TO_C) begin
            idle_d = idle_q + ONE_C;
            if (idle_q + ONE_C == TO_C) en_d = 1'b0;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               pidx_d = win_idx;
               pdig_d = win_dig;
`ifdef VGA_SCHED_RR_EN
               rr_d   = ~rr_q;
`endif
               if (win_bad) begin
                  ack_d[win_idx] = 1'b1;
                  err_d          = 1'b1;
               end
            end
         end
         WAIT_BLANK: begin
         end
         COMMIT: begin
            digit_d       = pdig_q;
            en_d          = 1'b1;
            ack_d[pidx_q] = 1'b1;
            hold_d        = MIN_C;
            idle_d        = '0;
         end
         HOLD: begin
            if (frame_tick && hold_q != '0) hold_d = hold_q - ONE_C;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
   end

   assign ack     = ack_q;
   assign err     = err_q;
   assign digit   = digit_q;
   assign digitEn = en_q;

endmodule
